// File: rtl/gray_codec_pipe_if.sv
// gray_codec_pipe_if: valid/ready stream bundle for the Gray/binary converter
interface gray_codec_pipe_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_step_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_step_err, err_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_step_err, err_count
    );
endinterface

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage Gray<->binary converter with Gray single-step checking
module gray_codec_pipe #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    gray_codec_pipe_if.slave  bus
);
    logic             s1_v, s2_v;
    logic [WIDTH-1:0] s1_data, s2_data;
    logic             s1_mode, s2_mode;
    logic             s1_err, s2_err;
    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] diff, g2b, conv;
    logic             step_err, s1_load, s2_load;

    assign s2_load  = s1_v && (!s2_v || bus.out_ready);
    assign bus.in_ready = !rst && (!s1_v || s2_load);
    assign s1_load  = bus.in_valid && bus.in_ready;
    assign diff     = bus.in_data ^ prev_gray;
    assign step_err = !bus.in_mode && have_prev && |(diff & (diff - WIDTH'(1)));

    // Gray to binary: each binary bit is the parity of the Gray bits at and above it
    always_comb begin
        g2b = '0;
        for (int i = 0; i < WIDTH; i++) g2b[i] = ^(s1_data >> i);
        conv = s1_mode ? (s1_data ^ (s1_data >> 1)) : g2b;
    end

    // pipeline stages, step-check history and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= 1'b0;
            s1_err    <= 1'b0;
            s2_data   <= '0;
            s2_mode   <= 1'b0;
            s2_err    <= 1'b0;
            prev_gray <= '0;
            have_prev <= 1'b0;
            err_count <= '0;
        end else begin
            s1_v <= s1_load || (s1_v && !s2_load);
            s2_v <= s2_load || (s2_v && !bus.out_ready);
            if (s1_load) begin
                s1_data   <= bus.in_data;
                s1_mode   <= bus.in_mode;
                s1_err    <= step_err;
                have_prev <= !bus.in_mode;
                if (!bus.in_mode) prev_gray <= bus.in_data;
            end
            if (s2_load) begin
                s2_data <= conv;
                s2_mode <= s1_mode;
                s2_err  <= s1_err;
                if (s1_err && err_count != '1) err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign bus.out_valid    = s2_v;
    assign bus.out_data     = s2_data;
    assign bus.out_mode     = s2_mode;
    assign bus.out_step_err = s2_err;
    assign bus.err_count    = err_count;
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: directed checks of conversion, step check, backpressure and reset
module tb_gray_codec_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;
    int   tx, rx, last;
    logic [3:0] qin[$], qexp[$];
    logic       qmode[$], qerr[$];
    logic [3:0] bp[6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [3:0] bpx[6] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101};

    gray_codec_pipe_if #(.WIDTH(4), .ERR_W(2)) bus ();
    gray_codec_pipe #(.WIDTH(4), .ERR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic add(input logic [3:0] d, input logic m, input logic [3:0] e, input logic er);
        qin.push_back(d);
        qmode.push_back(m);
        qexp.push_back(e);
        qerr.push_back(er);
    endtask

    task automatic stream(input string tag);
        int n = qin.size();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk({tag, " valid"}, bus.out_valid, 1);
                chk({tag, " data"}, bus.out_data, qexp[k-2]);
                chk({tag, " mode"}, bus.out_mode, qmode[k-2]);
                chk({tag, " err"}, bus.out_step_err, qerr[k-2]);
            end
            if (k < n) begin
                bus.in_valid = 1'b1;
                bus.in_data  = qin[k];
                bus.in_mode  = qmode[k];
            end else bus.in_valid = 1'b0;
        end
        qin.delete();
        qmode.delete();
        qexp.delete();
        qerr.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mode = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready during rst", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst out_mode", bus.out_mode, 0);
        chk("rst out_step_err", bus.out_step_err, 0);
        chk("rst err_count", bus.err_count, 0);

        add(4'b1111, 0, 4'b1010, 0);
        add(4'b1110, 0, 4'b1011, 0);
        add(4'b1000, 0, 4'b1111, 1);
        add(4'b1100, 0, 4'b1000, 0);
        add(4'b0100, 0, 4'b0111, 0);
        stream("g2b");
        chk("g2b err_count", bus.err_count, 1);

        add(4'b0101, 1, 4'b0111, 0);
        add(4'b1111, 1, 4'b1000, 0);
        add(4'b0000, 1, 4'b0000, 0);
        stream("b2g");
        chk("b2g err_count", bus.err_count, 1);

        do_reset();
        add(4'b0000, 0, 4'b0000, 0);
        add(4'b0001, 0, 4'b0001, 0);
        add(4'b0011, 0, 4'b0010, 0);
        add(4'b0011, 0, 4'b0010, 0);
        add(4'b0000, 0, 4'b0000, 1);
        add(4'b0000, 1, 4'b0000, 0);
        add(4'b1111, 0, 4'b1010, 0);
        stream("step");
        chk("step err_count", bus.err_count, 1);

        do_reset();
        tx = 0;
        rx = 0;
        last = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 4);
            bus.in_valid = (tx < 6);
            bus.in_data = bp[tx < 6 ? tx : 0];
            bus.in_mode = 1'b1;
            #1;
            if (c == 2) begin
                chk("bp in_ready low", bus.in_ready, 0);
                chk("bp accepted", tx, 2);
            end
            if (c >= 2 && c < 4) begin
                chk("bp hold valid", bus.out_valid, 1);
                chk("bp hold data", bus.out_data, 4'b0001);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rx < 6) chk("bp order", bus.out_data, bpx[rx]);
                rx++;
                last = c;
            end
            if (bus.in_valid && bus.in_ready) tx++;
        end
        chk("bp out count", rx, 6);
        chk("bp last cycle", last, 9);

        do_reset();
        add(4'b0000, 0, 4'b0000, 0);
        add(4'b0011, 0, 4'b0010, 1);
        add(4'b0000, 0, 4'b0000, 1);
        add(4'b0011, 0, 4'b0010, 1);
        add(4'b0000, 0, 4'b0000, 1);
        add(4'b0011, 0, 4'b0010, 1);
        stream("sat");
        @(negedge clk);
        chk("sat err_count", bus.err_count, 3);

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mode = 1'b0;
        bus.in_data = 4'b0000;
        @(negedge clk);
        bus.in_data = 4'b1111;
        @(negedge clk);
        chk("mid both full", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid in_ready in rst", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("mid out_valid", bus.out_valid, 0);
        chk("mid err_count", bus.err_count, 0);
        chk("mid in_ready", bus.in_ready, 1);
        chk("mid out_data", bus.out_data, 0);
        @(negedge clk);
        chk("mid no ghost", bus.out_valid, 0);
        add(4'b0111, 0, 4'b0101, 0);
        stream("post rst");
        chk("post rst err_count", bus.err_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
